// File: rtl/cnn_seq_ctrl.sv
// Purpose: frame sequencer; streams an IMG_W x IMG_H image from memory to the conv datapath, clamps results and writes them back.
// Latency: first read request the cycle after start_i; one read per 2 cycles on zero-wait memory; pixel strobe in the rvalid cycle.
// Backpressure: res_ready_o drops combinationally when the write FIFO is full; a memory request is held stable until mem_gnt_i.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   start_i, abort_i              frame control (start honoured in IDLE, abort in RUN/DRAIN)
//   in_base_i, out_base_i         byte base addresses latched at start
//   busy_o, done_o                status (done_o pulses once on normal completion)
//   mem_*                         single shared memory port, one transaction outstanding
//   pix_o, pix_valid_o            pixel stream to the line buffer
//   res_data_i/valid_i/ready_o    signed datapath results
// Optional feature: define CNN_SEQ_POOL_EN for 2x2 max pooling of the clamped results.
module cnn_seq_ctrl #(
    parameter int IMG_W       = 28,
    parameter int IMG_H       = 28,
    parameter int ADDR_WIDTH  = 32,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_WIDTH-1:0] in_base_i,
    input  logic [ADDR_WIDTH-1:0] out_base_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [7:0]            mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [7:0]            mem_rdata_i,
    output logic [7:0]            pix_o,
    output logic                  pix_valid_o,
    input  logic [31:0]           res_data_i,
    input  logic                  res_valid_i,
    output logic                  res_ready_o
);
    localparam logic [ADDR_WIDTH-1:0] N_PIX = ADDR_WIDTH'(IMG_W * IMG_H);
    localparam logic [ADDR_WIDTH-1:0] N_RES = ADDR_WIDTH'((IMG_W - 2) * (IMG_H - 2));
`ifdef CNN_SEQ_POOL_EN
    localparam logic [ADDR_WIDTH-1:0] N_OUT = ADDR_WIDTH'((IMG_W - 2) * (IMG_H - 2) / 4);
`else
    localparam logic [ADDR_WIDTH-1:0] N_OUT = N_RES;
`endif
    localparam int FA = $clog2(WFIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_ABORT, S_DONE} state_t;
    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] in_base_q, out_base_q, pix_cnt_q, res_cnt_q, wr_cnt_q;
    logic                  req_q, we_q, out_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            wdata_q;

    logic [7:0]  fifo_mem [WFIFO_DEPTH];
    logic [FA-1:0] wr_ptr_q, rd_ptr_q;
    logic [FA:0] fifo_cnt_q;

    logic active, fifo_empty, fifo_full, gnt_fire, rsp_fire, port_idle, port_free;
    logic issue_ok, issue_wr, issue_rd, res_fire, start_fire, flush;
    logic push_vld, pop_vld;
    logic [7:0] clamp_dat, push_dat;

    assign active     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == (FA+1)'(WFIFO_DEPTH));
    assign gnt_fire   = req_q && mem_gnt_i;
    assign rsp_fire   = out_q && mem_rvalid_i;
    assign port_idle  = !req_q && !out_q;
    // The port frees up at the end of the rvalid cycle, so the next request
    // is registered on that edge and appears the following cycle.
    assign port_free  = port_idle || rsp_fire;
    assign issue_ok   = active && !abort_i && port_free;
    assign issue_wr   = issue_ok && !fifo_empty;
    assign issue_rd   = issue_ok && fifo_empty && (pix_cnt_q < N_PIX);
    assign res_fire   = res_valid_i && res_ready_o;
    assign start_fire = (state_q == S_IDLE) && start_i;
    assign flush      = (state_q == S_ABORT) && port_idle;
    assign pop_vld    = gnt_fire && we_q;

    always_comb begin
        clamp_dat = res_data_i[7:0];
        if (res_data_i[31])          clamp_dat = 8'h00;
        else if (|res_data_i[30:8])  clamp_dat = 8'hFF;
    end

`ifdef CNN_SEQ_POOL_EN
    localparam int RW = IMG_W - 2;
    localparam int PW = RW / 2;
    localparam int CW = $clog2(RW);

    logic [7:0]    row_buf [PW];
    logic [CW-1:0] col_q;
    logic          row_odd_q;
    logic [7:0]    first_q, pair_max, buf_val;

    assign pair_max = (first_q > clamp_dat) ? first_q : clamp_dat;
    assign buf_val  = row_buf[col_q[CW-1:1]];
    assign push_vld = res_fire && row_odd_q && col_q[0];
    assign push_dat = (buf_val > pair_max) ? buf_val : pair_max;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q     <= '0;
            row_odd_q <= 1'b0;
            first_q   <= '0;
            for (int i = 0; i < PW; i++) row_buf[i] <= '0;
        end else if (start_fire) begin
            col_q     <= '0;
            row_odd_q <= 1'b0;
        end else if (res_fire) begin
            if (!col_q[0])      first_q <= clamp_dat;
            else if (!row_odd_q) row_buf[col_q[CW-1:1]] <= pair_max;
            if (col_q == CW'(RW - 1)) begin
                col_q     <= '0;
                row_odd_q <= !row_odd_q;
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end
`else
    assign push_vld = res_fire;
    assign push_dat = clamp_dat;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN: begin
                if (abort_i)               state_d = S_ABORT;
                else if (pix_cnt_q == N_PIX) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort_i) state_d = S_ABORT;
                else if ((wr_cnt_q == N_OUT) && fifo_empty && port_idle) state_d = S_DONE;
            end
            S_ABORT: if (port_idle) state_d = S_IDLE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_DONE);
        res_ready_o = active && !fifo_full && (res_cnt_q < N_RES);
        mem_req_o   = req_q;
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        // A read returning during ABORT is swallowed here.
        pix_valid_o = rsp_fire && !we_q && active;
        pix_o       = pix_valid_o ? mem_rdata_i : 8'h00;
    end

    // Memory port, counters and bases
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_base_q  <= '0;
            out_base_q <= '0;
            pix_cnt_q  <= '0;
            res_cnt_q  <= '0;
            wr_cnt_q   <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            out_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else if (start_fire) begin
            in_base_q  <= in_base_i;
            out_base_q <= out_base_i;
            pix_cnt_q  <= '0;
            res_cnt_q  <= '0;
            wr_cnt_q   <= '0;
            req_q      <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= in_base_i;
        end else begin
            if (gnt_fire) begin
                req_q <= 1'b0;
                out_q <= 1'b1;
                if (we_q) wr_cnt_q  <= wr_cnt_q + ADDR_WIDTH'(1);
                else      pix_cnt_q <= pix_cnt_q + ADDR_WIDTH'(1);
            end
            if (rsp_fire) out_q <= 1'b0;
            if (issue_wr) begin
                req_q   <= 1'b1;
                we_q    <= 1'b1;
                addr_q  <= out_base_q + wr_cnt_q;
                wdata_q <= fifo_mem[rd_ptr_q];
            end else if (issue_rd) begin
                req_q  <= 1'b1;
                we_q   <= 1'b0;
                addr_q <= in_base_q + pix_cnt_q;
            end
            if (res_fire) res_cnt_q <= res_cnt_q + ADDR_WIDTH'(1);
        end
    end

    // Write FIFO; the head stays in place until its write is granted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else if (flush || start_fire) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push_vld) wr_ptr_q <= wr_ptr_q + FA'(1);
            if (pop_vld)  rd_ptr_q <= rd_ptr_q + FA'(1);
            if (push_vld && !pop_vld)      fifo_cnt_q <= fifo_cnt_q + (FA+1)'(1);
            else if (!push_vld && pop_vld) fifo_cnt_q <= fifo_cnt_q - (FA+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_vld) fifo_mem[wr_ptr_q] <= push_dat;
    end
endmodule
